// File: rtl/meas_pkg.sv
// Shared state encoding and default timing constants for the measurement sequencer.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_MEAS = 3'd1,
        ST_CONV      = 3'd2,
        ST_WAIT_CONV = 3'd3,
        ST_LATCH     = 3'd4
    } state_t;

    localparam int PERIOD_MS_DEF = 200;
    localparam int TMO_MS_DEF    = 500;
    localparam int CNT_W         = 10;

endpackage

// File: rtl/ms_cnt.sv
// Millisecond tick counter: clear has priority over enable; tc_o flags the terminal count.
// Latency: count updates on the edge after en_i; no backpressure.
module ms_cnt #(
    parameter int W  = 10,
    parameter int TC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == W'(TC));

endmodule

// File: rtl/meas_seq.sv
// Periodic measure -> BCD convert -> display sequencer with per-phase timeout.
// Latency: meas_ok->conv_st 2 cycles, conv_done->upd 1 cycle; strobes are single-cycle, no backpressure.
module meas_seq
    import meas_pkg::*;
#(
    parameter int PERIOD_MS = PERIOD_MS_DEF,
    parameter int TMO_MS    = TMO_MS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce1ms,
    input  logic        sel,
    input  logic        hold,
    input  logic        meas_ok,
    input  logic [11:0] meas_rms,
    input  logic [11:0] meas_pic,
    output logic        conv_st,
    output logic [11:0] conv_bin,
    input  logic        conv_done,
    input  logic [15:0] conv_dec,
    output logic [15:0] disp_dat,
    output logic        upd,
    output logic        err,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [11:0] conv_bin_q, conv_bin_d;
    logic [15:0] dec_q, dec_d;
    logic [15:0] disp_q, disp_d;
    logic        conv_st_q, conv_st_d;
    logic        upd_q, upd_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic in_idle, waiting, per_tc, tmo_tc, wrap, tmo;

    assign in_idle = (state_q == ST_IDLE);
    assign waiting = (state_q == ST_WAIT_MEAS) || (state_q == ST_WAIT_CONV);
    assign wrap    = in_idle && ce1ms && per_tc;
    assign tmo     = waiting && ce1ms && tmo_tc;

    // Period counter only runs in IDLE, so every return to IDLE restarts from zero.
    ms_cnt #(.W(CNT_W), .TC(PERIOD_MS - 1)) u_per_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (wrap),
        .en_i  (in_idle && ce1ms),
        .tc_o  (per_tc)
    );

    // Held at zero outside the wait states, so each wait phase starts a fresh timeout.
    ms_cnt #(.W(CNT_W), .TC(TMO_MS - 1)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!waiting),
        .en_i  (waiting && ce1ms),
        .tc_o  (tmo_tc)
    );

    always_comb begin
        state_d    = state_q;
        conv_bin_d = conv_bin_q;
        dec_d      = dec_q;
        disp_d     = disp_q;
        err_d      = err_q;
        conv_st_d  = 1'b0;
        upd_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wrap && !hold) state_d = ST_WAIT_MEAS;
            end
            ST_WAIT_MEAS: begin
                // A strobe arriving with the final tick beats the timeout.
                if (meas_ok) begin
                    conv_bin_d = sel ? meas_pic : meas_rms;
                    state_d    = ST_CONV;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                conv_st_d = 1'b1;
                state_d   = ST_WAIT_CONV;
            end
            ST_WAIT_CONV: begin
                if (conv_done) begin
                    dec_d   = conv_dec;
                    upd_d   = 1'b1;
                    state_d = ST_LATCH;
                end else if (tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                disp_d  = dec_q;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            conv_bin_q <= '0;
            dec_q      <= '0;
            disp_q     <= '0;
            conv_st_q  <= 1'b0;
            upd_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_bin_q <= conv_bin_d;
            dec_q      <= dec_d;
            disp_q     <= disp_d;
            conv_st_q  <= conv_st_d;
            upd_q      <= upd_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign conv_st  = conv_st_q;
    assign conv_bin = conv_bin_q;
    assign disp_dat = disp_q;
    assign upd      = upd_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_meas_seq.sv
// Bench for meas_seq with PERIOD_MS=4, TMO_MS=5: vector table plus scoreboarded corner sequences.
module tb_meas_seq;

    localparam int P = 4;
    localparam int T = 5;

    logic        clk = 1'b0;
    logic        rst, ce1ms, sel, hold, meas_ok, conv_done;
    logic [11:0] meas_rms, meas_pic;
    logic [15:0] conv_dec;
    logic        conv_st, upd, err, busy;
    logic [11:0] conv_bin;
    logic [15:0] disp_dat;

    meas_seq #(.PERIOD_MS(P), .TMO_MS(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce1ms     (ce1ms),
        .sel       (sel),
        .hold      (hold),
        .meas_ok   (meas_ok),
        .meas_rms  (meas_rms),
        .meas_pic  (meas_pic),
        .conv_st   (conv_st),
        .conv_bin  (conv_bin),
        .conv_done (conv_done),
        .conv_dec  (conv_dec),
        .disp_dat  (disp_dat),
        .upd       (upd),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int n_cst = 0;
    int n_upd = 0;
    logic [11:0] q_bin[$];
    logic [15:0] q_disp[$];
    logic        upd_pend = 1'b0;
    logic [15:0] last_disp = 16'h0000;

    typedef struct {
        logic        sel;
        logic [11:0] rms;
        logic [11:0] pic;
        logic [15:0] dec;
        logic [11:0] e_bin;
        logic [15:0] e_disp;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: conv_bin checked on every conv_st, disp_dat one cycle after every upd.
    always @(negedge clk) begin
        if (upd_pend) begin
            upd_pend = 1'b0;
            if (q_disp.size() == 0) chk("sb_unexpected_upd", 32'(disp_dat), 32'hFFFF_FFFF);
            else chk("sb_disp_dat", 32'(disp_dat), 32'(q_disp.pop_front()));
        end
        if (upd === 1'b1) begin
            n_upd++;
            upd_pend = 1'b1;
        end
        if (conv_st === 1'b1) begin
            n_cst++;
            if (q_bin.size() == 0) chk("sb_unexpected_conv_st", 32'(conv_bin), 32'hFFFF_FFFF);
            else chk("sb_conv_bin", 32'(conv_bin), 32'(q_bin.pop_front()));
        end
    end

    task automatic cyc(input logic ce);
        ce1ms = ce;
        @(posedge clk);
        #1;
        ce1ms = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic capture(input logic s, input logic [11:0] r, input logic [11:0] p,
                           input logic ce, input logic [11:0] eb);
        sel = s; meas_rms = r; meas_pic = p; meas_ok = 1'b1;
        q_bin.push_back(eb);
        cyc(ce);
        meas_ok = 1'b0;
        chk("conv_st_lat1", 32'(conv_st), 32'd0);
        cyc(1'b0);
        chk("conv_st_lat2", 32'(conv_st), 32'd1);
        chk("conv_bin", 32'(conv_bin), 32'(eb));
        cyc(1'b0);
        chk("conv_st_width", 32'(conv_st), 32'd0);
    endtask

    task automatic convert(input logic [15:0] d, input logic [15:0] ed);
        conv_dec = d; conv_done = 1'b1;
        q_disp.push_back(ed);
        cyc(1'b0);
        conv_done = 1'b0;
        chk("upd_lat", 32'(upd), 32'd1);
        cyc(1'b0);
        chk("upd_width", 32'(upd), 32'd0);
        chk("disp_dat", 32'(disp_dat), 32'(ed));
        chk("err_clear", 32'(err), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        last_disp = ed;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_conv_st"},  32'(conv_st),  32'd0);
        chk({tag, "_conv_bin"}, 32'(conv_bin), 32'd0);
        chk({tag, "_disp_dat"}, 32'(disp_dat), 32'd0);
        chk({tag, "_upd"},      32'(upd),      32'd0);
        chk({tag, "_err"},      32'(err),      32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    int c0;

    initial begin
        vecs[0] = '{1'b0, 12'h3E8, 12'h123, 16'h1000, 12'h3E8, 16'h1000};
        vecs[1] = '{1'b1, 12'h001, 12'hFFF, 16'h4095, 12'hFFF, 16'h4095};
        vecs[2] = '{1'b0, 12'h000, 12'hABC, 16'h0000, 12'h000, 16'h0000};
        vecs[3] = '{1'b1, 12'h555, 12'h7FF, 16'h2047, 12'h7FF, 16'h2047};

        rst = 1'b1; ce1ms = 1'b0; sel = 1'b0; hold = 1'b0; meas_ok = 1'b0;
        conv_done = 1'b0; meas_rms = '0; meas_pic = '0; conv_dec = '0;
        cyc(1'b0); cyc(1'b0);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            ticks(P - 1);
            chk("busy_pre_wrap", 32'(busy), 32'd0);
            ticks(1);
            chk("busy_wrap", 32'(busy), 32'd1);
            capture(vecs[i].sel, vecs[i].rms, vecs[i].pic, 1'b0, vecs[i].e_bin);
            convert(vecs[i].dec, vecs[i].e_disp);
        end

        // Measurement timeout, then a good cycle clears err.
        c0 = n_cst;
        ticks(P);
        ticks(T - 1);
        chk("tmo_meas_pre_err", 32'(err), 32'd0);
        chk("tmo_meas_pre_busy", 32'(busy), 32'd1);
        ticks(1);
        chk("tmo_meas_err", 32'(err), 32'd1);
        chk("tmo_meas_busy", 32'(busy), 32'd0);
        chk("tmo_meas_no_conv_st", 32'(n_cst), 32'(c0));
        chk("tmo_meas_disp_kept", 32'(disp_dat), 32'(last_disp));
        ticks(P);
        capture(1'b0, 12'h3E8, 12'h000, 1'b0, 12'h3E8);
        convert(16'h1000, 16'h1000);

        // Hold across three wraps; sel changed meanwhile only matters at next capture.
        c0 = n_cst;
        hold = 1'b1;
        for (int w = 0; w < 3; w++) begin
            ticks(P);
            chk("hold_busy", 32'(busy), 32'd0);
        end
        chk("hold_no_conv_st", 32'(n_cst), 32'(c0));
        hold = 1'b0;
        ticks(P);
        chk("hold_release_busy", 32'(busy), 32'd1);

        // Strobe on the same cycle as the final timeout tick.
        ticks(T - 1);
        capture(1'b1, 12'h222, 12'h0EE, 1'b1, 12'h0EE);
        chk("race_err", 32'(err), 32'd0);
        convert(16'h0238, 16'h0238);

        // Stray strobes in IDLE are ignored.
        c0 = n_upd;
        meas_rms = 12'h777; meas_pic = 12'h777; meas_ok = 1'b1; conv_done = 1'b1;
        conv_dec = 16'h9999;
        cyc(1'b0);
        meas_ok = 1'b0; conv_done = 1'b0;
        cyc(1'b0);
        chk("stray_upd", 32'(upd), 32'd0);
        chk("stray_upd_count", 32'(n_upd), 32'(c0));
        chk("stray_conv_bin", 32'(conv_bin), 32'h0EE);
        chk("stray_busy", 32'(busy), 32'd0);
        cyc(1'b0);
        chk("stray_disp", 32'(disp_dat), 32'(last_disp));

        // Conversion timeout.
        c0 = n_upd;
        ticks(P);
        capture(1'b0, 12'h100, 12'h200, 1'b0, 12'h100);
        ticks(T - 1);
        chk("tmo_conv_pre_err", 32'(err), 32'd0);
        ticks(1);
        chk("tmo_conv_err", 32'(err), 32'd1);
        chk("tmo_conv_busy", 32'(busy), 32'd0);
        chk("tmo_conv_no_upd", 32'(n_upd), 32'(c0));
        chk("tmo_conv_disp_kept", 32'(disp_dat), 32'(last_disp));

        // Reset in the middle of WAIT_CONV, with err still set.
        ticks(P);
        capture(1'b1, 12'h000, 12'h9AB, 1'b0, 12'h9AB);
        rst = 1'b1;
        cyc(1'b0);
        chk_reset_vals("midrst");
        rst = 1'b0;
        c0 = n_upd;
        conv_dec = 16'h5555; conv_done = 1'b1;
        cyc(1'b0);
        conv_done = 1'b0;
        cyc(1'b0);
        chk("midrst_late_upd", 32'(n_upd), 32'(c0));
        chk("midrst_disp", 32'(disp_dat), 32'd0);
        ticks(P - 1);
        chk("midrst_pre_wrap", 32'(busy), 32'd0);
        ticks(1);
        chk("midrst_wrap", 32'(busy), 32'd1);

        cyc(1'b0); cyc(1'b0);
        chk("sb_bin_drained", 32'(q_bin.size()), 32'd0);
        chk("sb_disp_drained", 32'(q_disp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
